// File: rtl/alu_ex_stage_pkg.sv
// Pipeline definitions shared by the ALU-control decoder and the execute stage.
// Contents: ALU op-code width and op-code constants.
package alu_ex_stage_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'd5;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'd9;

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// Combinational ALU for the execute stage.
// Ports: op (ALU op code), a/b (operands), shamt (shift amount),
//        result (WIDTH-bit result), overflow (signed overflow, add/sub only).
module alu_core
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic [ALU_W-1:0]   op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic               overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lessThan;
    logic             addOvf;
    logic             subOvf;

    assign sum  = a + b;
    assign diff = a - b;

    // Direct signed compare, so slt stays correct when a-b overflows.
    assign lessThan = $signed(a) < $signed(b);

    assign addOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign subOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    // Result and overflow select; reserved codes yield zero.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                result   = sum;
                overflow = addOvf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = subOvf;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lessThan};
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $unsigned($signed(b) >>> shamt);
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU plus EX/MEM boundary register with flush > stall > load.
// Inputs: ID/EX operands, ALU op, side-band (rd, regWrite, JR), hazard stall/flush.
// Outputs: registered result, zero, overflow, rd, qualified regWrite, JR flag/target, valid.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned REG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iValid,
    input  logic [ALU_W-1:0]   iALUctrl,
    input  logic [WIDTH-1:0]   iSrcA,
    input  logic [WIDTH-1:0]   iSrcB,
    input  logic [SHAMT_W-1:0] iShamt,
    input  logic [REG_W-1:0]   iRd,
    input  logic               iRegWrite,
    input  logic               iJR,
    input  logic               iStall,
    input  logic               iFlush,
    output logic               oValid,
    output logic [WIDTH-1:0]   oResult,
    output logic               oZero,
    output logic               oOverflow,
    output logic [REG_W-1:0]   oRd,
    output logic               oRegWrite,
    output logic               oJR,
    output logic [WIDTH-1:0]   oJRTarget
);

    if (SHAMT_W != $clog2(WIDTH)) begin : gShamtCheck
        $error("SHAMT_W must equal log2(WIDTH)");
    end

    logic [WIDTH-1:0] aluResult;
    logic             aluOverflow;

    alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) uAluCore (
        .op       (iALUctrl),
        .a        (iSrcA),
        .b        (iSrcB),
        .shamt    (iShamt),
        .result   (aluResult),
        .overflow (aluOverflow)
    );

    // EX/MEM register; a flush or an invalid load both insert a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid    <= 1'b0;
            oResult   <= '0;
            oZero     <= 1'b0;
            oOverflow <= 1'b0;
            oRd       <= '0;
            oRegWrite <= 1'b0;
            oJR       <= 1'b0;
            oJRTarget <= '0;
        end else if (iFlush || (!iStall && !iValid)) begin
            oValid    <= 1'b0;
            oResult   <= '0;
            oZero     <= 1'b0;
            oOverflow <= 1'b0;
            oRd       <= '0;
            oRegWrite <= 1'b0;
            oJR       <= 1'b0;
            oJRTarget <= '0;
        end else if (!iStall) begin
            oValid    <= 1'b1;
            oResult   <= aluResult;
            oZero     <= (aluResult == '0);
            oOverflow <= aluOverflow;
            oRd       <= iRd;
            oRegWrite <= iRegWrite & ~aluOverflow;
            oJR       <= iJR;
            oJRTarget <= iSrcA;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: driver pushes hand-computed expectations,
// monitor pops and compares one entry after each clock edge.
module tb_alu_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        iValid;
    logic [3:0]  iALUctrl;
    logic [31:0] iSrcA;
    logic [31:0] iSrcB;
    logic [4:0]  iShamt;
    logic [4:0]  iRd;
    logic        iRegWrite;
    logic        iJR;
    logic        iStall;
    logic        iFlush;
    logic        oValid;
    logic [31:0] oResult;
    logic        oZero;
    logic        oOverflow;
    logic [4:0]  oRd;
    logic        oRegWrite;
    logic        oJR;
    logic [31:0] oJRTarget;

    alu_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iValid    (iValid),
        .iALUctrl  (iALUctrl),
        .iSrcA     (iSrcA),
        .iSrcB     (iSrcB),
        .iShamt    (iShamt),
        .iRd       (iRd),
        .iRegWrite (iRegWrite),
        .iJR       (iJR),
        .iStall    (iStall),
        .iFlush    (iFlush),
        .oValid    (oValid),
        .oResult   (oResult),
        .oZero     (oZero),
        .oOverflow (oOverflow),
        .oRd       (oRd),
        .oRegWrite (oRegWrite),
        .oJR       (oJR),
        .oJRTarget (oJRTarget)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [4:0]  rd;
        logic        rw;
        logic        jr;
        logic [31:0] jrt;
    } exp_t;

    exp_t q[$];
    exp_t lastExp;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one vector (zero time) and push what the EX/MEM register must hold after the next edge.
    task automatic drv(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd, input logic rw, input logic jr,
                       input logic st, input logic fl, input logic [31:0] expRes, input logic expOvf);
        exp_t e;
        iValid = v; iALUctrl = op; iSrcA = a; iSrcB = b; iShamt = sh; iRd = rd;
        iRegWrite = rw; iJR = jr; iStall = st; iFlush = fl;
        if (fl || (!st && !v)) begin
            e = '0;
        end else if (st) begin
            e = lastExp;
        end else begin
            e.valid  = 1'b1;
            e.result = expRes;
            e.zero   = (expRes == 32'h0);
            e.ovf    = expOvf;
            e.rd     = rd;
            e.rw     = rw & ~expOvf;
            e.jr     = jr;
            e.jrt    = a;
        end
        lastExp = e;
        q.push_back(e);
    endtask

    task automatic chkZero(input string tag);
        chk({tag, " valid"},  32'(oValid),    32'h0);
        chk({tag, " result"}, oResult,        32'h0);
        chk({tag, " zero"},   32'(oZero),     32'h0);
        chk({tag, " ovf"},    32'(oOverflow), 32'h0);
        chk({tag, " rd"},     32'(oRd),       32'h0);
        chk({tag, " rw"},     32'(oRegWrite), 32'h0);
        chk({tag, " jr"},     32'(oJR),       32'h0);
        chk({tag, " jrt"},    oJRTarget,      32'h0);
    endtask

    // Monitor: one expectation per edge whenever the driver has issued one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid",  32'(oValid),    32'(e.valid));
                chk("result", oResult,        e.result);
                chk("zero",   32'(oZero),     32'(e.zero));
                chk("ovf",    32'(oOverflow), 32'(e.ovf));
                chk("rd",     32'(oRd),       32'(e.rd));
                chk("rw",     32'(oRegWrite), 32'(e.rw));
                chk("jr",     32'(oJR),       32'(e.jr));
                chk("jrt",    oJRTarget,      e.jrt);
            end
        end
    end

    initial begin
        lastExp = '0;
        rst_n = 1'b0;
        iValid = 1'b0; iALUctrl = 4'd0; iSrcA = 32'h0; iSrcB = 32'h0; iShamt = 5'd0;
        iRd = 5'd0; iRegWrite = 1'b0; iJR = 1'b0; iStall = 1'b0; iFlush = 1'b0;
        repeat (2) @(posedge clk);
        #1 chkZero("reset");

        // Load valid data, stall it, then assert reset mid-cycle while stalled.
        @(negedge clk); rst_n = 1'b1;
        drv(1, 4'd0, 32'd3, 32'd4, 5'd0, 5'd3, 1, 0, 0, 0, 32'd7, 0);
        @(negedge clk); drv(1, 4'd0, 32'd8, 32'd8, 5'd0, 5'd4, 1, 0, 1, 0, 32'd16, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        lastExp = '0;
        #1 chkZero("async reset");
        @(posedge clk); #1 chkZero("held in reset");

        @(negedge clk); rst_n = 1'b1;
        drv(1, 4'd0, 32'd5, 32'd7, 5'd0, 5'd1, 1, 0, 0, 0, 32'd12, 0);
        // Overflow cases
        @(negedge clk); drv(1, 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 5'd2, 1, 0, 0, 0, 32'h80000000, 1);
        @(negedge clk); drv(1, 4'd1, 32'h80000000, 32'h1, 5'd0, 5'd2, 1, 0, 0, 0, 32'h7FFFFFFF, 1);
        @(negedge clk); drv(1, 4'd0, 32'h80000000, 32'h80000000, 5'd0, 5'd5, 1, 0, 0, 0, 32'h0, 1);
        @(negedge clk); drv(1, 4'd1, 32'd5, 32'd7, 5'd0, 5'd6, 1, 0, 0, 0, 32'hFFFFFFFE, 0);
        // slt and zero
        @(negedge clk); drv(1, 4'd4, 32'h80000000, 32'h1, 5'd0, 5'd7, 1, 0, 0, 0, 32'h1, 0);
        @(negedge clk); drv(1, 4'd4, 32'h1, 32'hFFFFFFFF, 5'd0, 5'd7, 1, 0, 0, 0, 32'h0, 0);
        @(negedge clk); drv(1, 4'd4, 32'h80000000, 32'h7FFFFFFF, 5'd0, 5'd8, 1, 0, 0, 0, 32'h1, 0);
        @(negedge clk); drv(1, 4'd1, 32'd9, 32'd9, 5'd0, 5'd9, 1, 0, 0, 0, 32'h0, 0);
        // Shifts and logic
        @(negedge clk); drv(1, 4'd7, 32'h0, 32'h80000010, 5'd4, 5'd10, 1, 0, 0, 0, 32'h00000100, 0);
        @(negedge clk); drv(1, 4'd8, 32'h0, 32'h80000010, 5'd4, 5'd11, 1, 0, 0, 0, 32'h08000001, 0);
        @(negedge clk); drv(1, 4'd9, 32'h0, 32'h80000010, 5'd4, 5'd12, 1, 0, 0, 0, 32'hF8000001, 0);
        @(negedge clk); drv(1, 4'd6, 32'h0, 32'h0, 5'd0, 5'd13, 1, 0, 0, 0, 32'hFFFFFFFF, 0);
        @(negedge clk); drv(1, 4'd2, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd14, 0, 0, 0, 0, 32'h0000F000, 0);
        @(negedge clk); drv(1, 4'd5, 32'h0000F0F0, 32'h0000FF00, 5'd0, 5'd15, 1, 0, 0, 0, 32'h00000FF0, 0);
        // Stall holds, flush beats stall
        @(negedge clk); drv(1, 4'd3, 32'd1, 32'd2, 5'd0, 5'd16, 1, 0, 0, 0, 32'd3, 0);
        @(negedge clk); drv(1, 4'd0, 32'd100, 32'd200, 5'd0, 5'd17, 1, 1, 1, 0, 32'd300, 0);
        @(negedge clk); drv(0, 4'd1, 32'd50, 32'd20, 5'd0, 5'd18, 0, 0, 1, 0, 32'd30, 0);
        @(negedge clk); drv(1, 4'd6, 32'h1, 32'h2, 5'd0, 5'd19, 1, 0, 1, 0, 32'hFFFFFFFC, 0);
        @(negedge clk); drv(1, 4'd0, 32'd1, 32'd1, 5'd0, 5'd20, 1, 0, 1, 1, 32'd2, 0);
        // JR, bubble, reserved code
        @(negedge clk); drv(1, 4'd0, 32'h00400020, 32'h0, 5'd0, 5'd0, 0, 1, 0, 0, 32'h00400020, 0);
        @(negedge clk); drv(0, 4'd0, 32'h00400040, 32'h0, 5'd0, 5'd0, 0, 1, 0, 0, 32'h00400040, 0);
        @(negedge clk); drv(1, 4'd12, 32'd5, 32'd3, 5'd2, 5'd21, 1, 0, 0, 0, 32'h0, 0);
        @(negedge clk); drv(1, 4'd0, 32'd1, 32'd1, 5'd0, 5'd22, 1, 0, 0, 1, 32'd2, 0);
        @(negedge clk); drv(0, 4'd0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ALU-control decoder and consumes its 4-bit ALU operation code.
- Computes the ALU result on the ID/EX operands and registers it, with its side-band fields, into the EX/MEM boundary.
- Supports hazard-unit stall and flush, and forwards the JR indication to the fetch-redirect logic.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- REG_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- iValid  input  1  ID/EX holds a real instruction (0 = bubble).
- iALUctrl  input  4  ALU op code: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor, 6 nor, 7 sll, 8 srl, 9 sra; 10-15 reserved.
- iSrcA  input  WIDTH  operand A (rs, already forwarded).
- iSrcB  input  WIDTH  operand B (rt or sign-extended immediate, already muxed).
- iShamt  input  SHAMT_W  shift amount for ops 7-9.
- iRd  input  REG_W  destination register index.
- iRegWrite  input  1  instruction writes the register file.
- iJR  input  1  instruction is JR.
- iStall  input  1  hold the EX/MEM register.
- iFlush  input  1  load a bubble into EX/MEM.
- oValid  output  1  EX/MEM holds a real instruction.
- oResult  output  WIDTH  registered ALU result.
- oZero  output  1  registered (oResult == 0).
- oOverflow  output  1  registered signed overflow (add/sub only).
- oRd  output  REG_W  registered destination index.
- oRegWrite  output  1  registered, qualified write enable.
- oJR  output  1  registered JR flag, qualified by valid.
- oJRTarget  output  WIDTH  registered iSrcA captured for JR.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs go to 0; oZero resets to 0, not 1. Outputs stay 0 until the first load after rst_n deasserts.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Priority at each rising edge: flush > stall > load.
- Flush: oValid, oRegWrite, oJR, oOverflow go to 0; oResult, oJRTarget, oRd go to 0; oZero goes to 0.
- Stall (no flush): every output register holds its value.
- Load with iValid=0: same as flush (bubble).
- Load with iValid=1: registers the values defined below.
- Arithmetic, all modulo 2^WIDTH:
  - add: A+B; sub: A-B.
  - and/or/xor: bitwise; nor: ~(A|B).
  - slt: 1 if signed A < signed B, else 0, zero-extended. Must be correct when A-B overflows.
  - sll: B << shamt; srl: B >> shamt logical; sra: B >>> shamt arithmetic (sign fill).
  - reserved codes 10-15: result 0, overflow 0.
- Overflow:
  - add: operands share a sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from A.
- oRegWrite = iRegWrite & ~overflow. A trapping add/sub never writes.
- oZero is computed from the final result written to oResult.
- oJR = iJR; oJRTarget = iSrcA (only meaningful when oJR=1).
- Reset mid-stall: reset wins immediately (asynchronous); the stall is irrelevant afterwards.
- Flush and stall together: flush wins and a bubble is loaded.

Decomposition:
- Shared package (pipeline defs): ALU op-code localparams ALU_ADD..ALU_SRA (0-9) and ALU_W=4. The ALU-control decoder must use the same constants.
- One combinational sub-module, alu_core: inputs op, A, B, shamt; outputs result and overflow.
- alu_ex_stage contains alu_core plus the EX/MEM register with its flush/stall priority.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with valid data loaded -> all outputs 0 immediately. Deassert, apply add 5+7 -> next edge oResult=12, oZero=0, oValid=1.
- Overflow: add 0x7FFFFFFF+1 with iRegWrite=1 -> oResult=0x80000000, oOverflow=1, oRegWrite=0. sub 0x80000000-1 -> oResult=0x7FFFFFFF, oOverflow=1.
- slt signed: A=0x80000000, B=1 -> oResult=1. A=1, B=0xFFFFFFFF -> oResult=0. sub 9-9 -> oResult=0, oZero=1.
- Shifts with B=0x80000010, shamt=4: sll -> 0x00000100; srl -> 0x08000001; sra -> 0xF8000001. nor 0,0 -> 0xFFFFFFFF.
- Stall/flush: load and 1|2 -> oResult=3. Assert iStall for 3 cycles while inputs change -> outputs stay 3. Assert iStall and iFlush together -> oValid=0, oRegWrite=0, oResult=0.
- JR and bubble: iJR=1, iSrcA=0x00400020 -> oJR=1, oJRTarget=0x00400020. Next cycle with iValid=0, iJR=1 -> oJR=0, oValid=0. Reserved code 12 -> oResult=0, oOverflow=0.
